// File: rtl/step_burst_gen.sv
// Burst generator for the single-step emulator clock gate: one start command
// becomes N go pulses, each followed by a guaranteed low gap.
module step_burst_gen #(
  parameter int CNT_WIDTH = 16,
  parameter int HIGH_CYC  = 1,
  parameter int LOW_CYC   = 1
) (
  input  logic                 __emu_clk,
  input  logic                 __emu_rst_n,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] n_steps_i,
  input  logic                 abort_i,
  output logic                 go_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o,
  output logic [CNT_WIDTH-1:0] steps_done_o
);

  localparam int PH_MAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] HIGH_LOAD = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0] LOW_LOAD  = PH_W'(LOW_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] target;
  logic [PH_W-1:0]      phase;
  logic                 abort_pend;
  logic                 drain_abort;

  // An abort seen on the very last LOW cycle must still be reported.
  assign drain_abort = abort_pend | abort_i;

  always_ff @(posedge __emu_clk or negedge __emu_rst_n) begin
    if (!__emu_rst_n) begin
      state        <= IDLE;
      target       <= '0;
      phase        <= '0;
      abort_pend   <= 1'b0;
      go_o         <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
      steps_done_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            target     <= n_steps_i;
            aborted_o  <= 1'b0;
            abort_pend <= 1'b0;
            if (n_steps_i != '0) begin
              steps_done_o <= CNT_WIDTH'(1);
              go_o         <= 1'b1;
              busy_o       <= 1'b1;
              phase        <= HIGH_LOAD;
              state        <= HIGH;
            end else begin
              steps_done_o <= '0;
              done_o       <= 1'b1;
            end
          end
        end

        // The rising edge already went out, so an abort here only cuts the
        // high time short; the full low gap still follows.
        HIGH: begin
          if (abort_i || phase == '0) begin
            go_o       <= 1'b0;
            phase      <= LOW_LOAD;
            abort_pend <= abort_i;
            state      <= LOW;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end

        LOW: begin
          if (phase == '0) begin
            if (drain_abort || steps_done_o == target) begin
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              aborted_o  <= drain_abort;
              abort_pend <= 1'b0;
              state      <= IDLE;
            end else begin
              go_o         <= 1'b1;
              steps_done_o <= steps_done_o + CNT_WIDTH'(1);
              phase        <= HIGH_LOAD;
              state        <= HIGH;
            end
          end else begin
            phase <= phase - PH_W'(1);
            if (abort_i) abort_pend <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
